// File: rtl/mpsoc_wb_burst_master.sv
// rtl/mpsoc_wb_burst_master.sv - Wishbone B3 initiator turning stream commands into classic/incrementing bursts
module mpsoc_wb_burst_master #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MAXLEN  = 16,
  parameter int TIMEOUT = 255,
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  typedef enum logic [1:0] {IDLE, LOAD, BUS} state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_next;
  logic          we_r, cyc_r;
  logic [AW-1:0] adr_r;
  logic [LW-1:0] rem_r;
  logic [DW-1:0] dat_r, rd_data_r;
  logic          rd_valid_r, done_r, err_r;
  logic [TW-1:0] tmo_r;

  logic accept, capture, beat_ok, abort, finish;
  logic tmo_hit, last_beat;

  assign tmo_hit   = (TIMEOUT != 0) && (tmo_r == TMO_LAST);
  assign last_beat = (rem_r <= LW'(1));

  // An ack in the same cycle as the timeout still counts; a bus error always wins.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    beat_ok    = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    wr_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = cmd_we ? LOAD : BUS;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          capture    = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wb_err_i || (tmo_hit && !wb_ack_i)) begin
          abort      = 1'b1;
          finish     = 1'b1;
          state_next = IDLE;
        end else if (wb_ack_i) begin
          beat_ok = 1'b1;
          if (last_beat) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else if (we_r) begin
            wr_ready = 1'b1;
            if (wr_valid) capture = 1'b1;
            else          state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      cyc_r      <= 1'b0;
      adr_r      <= '0;
      rem_r      <= '0;
      dat_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      tmo_r      <= '0;
    end else begin
      state      <= state_next;
      // cyc is held across write-data bubbles once the first beat has been presented
      cyc_r      <= (state_next == BUS) || ((state_next == LOAD) && cyc_r);
      rd_valid_r <= beat_ok && !we_r;
      done_r     <= finish;
      err_r      <= abort;
      if (accept) begin
        we_r  <= cmd_we;
        adr_r <= cmd_adr & ~AW'(3);
        rem_r <= (cmd_len == '0) ? LW'(1) : cmd_len;
      end
      if (capture) dat_r <= wr_data;
      if (beat_ok) begin
        rem_r <= rem_r - LW'(1);
        adr_r <= adr_r + AW'(4);
        if (!we_r) rd_data_r <= wb_dat_i;
      end
      if ((state != BUS) || wb_ack_i) tmo_r <= '0;
      else                            tmo_r <= tmo_r + TW'(1);
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign done      = done_r;
  assign err       = err_r;
  assign wb_adr_o  = adr_r;
  assign wb_dat_o  = dat_r;
  assign wb_we_o   = we_r;
  assign wb_cyc_o  = cyc_r;
  assign wb_stb_o  = (state == BUS);
  assign wb_sel_o  = cyc_r ? 4'hF : 4'h0;
  assign wb_bte_o  = 2'b00;
  assign wb_cti_o  = !cyc_r ? 3'b000 : (last_beat ? 3'b111 : 3'b010);

endmodule

// File: tb/tb_mpsoc_wb_burst_master.sv
// tb/tb_mpsoc_wb_burst_master.sv - randomized bench for mpsoc_wb_burst_master against a transaction-level model
module tb_mpsoc_wb_burst_master;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int MAXLEN  = 16;
  localparam int TIMEOUT = 8;
  localparam int LW      = $clog2(MAXLEN + 1);
  localparam int WORDS   = 1 << (AW - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic [1:0]    wb_bte;
  logic [2:0]    wb_cti;
  logic          wb_cyc, wb_stb, wb_ack, wb_err;

  mpsoc_wb_burst_master #(.AW(AW), .DW(DW), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_dat_i)
  );

  // Slave: registered ack one cycle after stb, streaming while cti=010
  logic [DW-1:0] sl_mem   [WORDS];
  logic [DW-1:0] init_mem [WORDS];
  logic [DW-1:0] ref_mem  [WORDS];
  logic          ack_q, sl_load;
  int            sl_cnt, sl_err_beat;
  bit            sl_no_ack;

  assign wb_err   = ack_q && wb_stb && (sl_err_beat > 0) && (sl_cnt == sl_err_beat - 1);
  assign wb_ack   = ack_q && wb_stb && !wb_err;
  assign wb_dat_i = sl_mem[wb_adr[AW-1:2]];

  always @(posedge clk) begin
    if (!rstn) begin
      ack_q  <= 1'b0;
      sl_cnt <= 0;
    end else begin
      ack_q <= wb_cyc && wb_stb && !sl_no_ack && !wb_err && !(ack_q && wb_cti != 3'b010);
      if (!wb_cyc)     sl_cnt <= 0;
      else if (wb_ack) sl_cnt <= sl_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (sl_load) for (int i = 0; i < WORDS; i++) sl_mem[i] <= init_mem[i];
    else if (wb_ack && wb_we) sl_mem[wb_adr[AW-1:2]] <= wb_dat_o;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where done was seen (or the budget ran out).
  task automatic run_cmd(input bit we, input logic [AW-1:0] adr, input int len, input int err_beat,
                         input bit no_ack, input int stall_pct, input int gap_at, input bit seq_data);
    int n, nexp, beats, c, rd_seen, stb_cycles, bubbles, first_rd_c, done_c, wr_idx, gap_left, base;
    bit started, ended, got_done, exp_err;
    logic [DW-1:0] wdat[$];
    logic [DW-1:0] exp_rd[$];
    n        = (len == 0) ? 1 : len;
    base     = int'(adr) & ~3;
    exp_err  = no_ack || (err_beat > 0 && err_beat <= n);
    nexp     = no_ack ? 0 : ((err_beat > 0 && err_beat <= n) ? err_beat - 1 : n);
    for (int i = 0; i < n; i++) wdat.push_back(seq_data ? 32'h11 * (i + 1) : $urandom);
    for (int i = 0; i < nexp; i++) begin
      int w;
      w = ((base + 4 * i) % (1 << AW)) / 4;
      if (we) ref_mem[w] = wdat[i];
      else    exp_rd.push_back(ref_mem[w]);
    end
    sl_err_beat = err_beat;
    sl_no_ack   = no_ack;
    beats = 0; rd_seen = 0; stb_cycles = 0; bubbles = 0; first_rd_c = 0; done_c = 0;
    wr_idx = 0; gap_left = 3; started = 0; ended = 0; got_done = 0;

    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = LW'(len);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 1;
    while (c <= 300 && !got_done) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (we && wr_idx < n) begin
        if (gap_at == wr_idx && gap_left > 0) begin
          wr_valid = 1'b0;
          gap_left--;
        end else begin
          wr_valid = ($urandom_range(99) >= stall_pct);
        end
        wr_data = wdat[wr_idx];
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 1) check("wr_ready_c1", 32'(wr_ready), 32'(we));
      if (wr_valid && wr_ready) wr_idx++;
      if (wb_stb) begin
        stb_cycles++;
        check("stb_needs_cyc", 32'(wb_cyc), 32'd1);
        if (we && beats < n) check("wdata", wb_dat_o, wdat[beats]);
      end
      if (wb_cyc) begin
        started = 1;
        if (!wb_stb) bubbles++;
        check("sel", 32'(wb_sel), 32'hF);
        check("bte", 32'(wb_bte), 32'd0);
        check("we", 32'(wb_we), 32'(we));
        check("adr", 32'(wb_adr), 32'((base + 4 * beats) % (1 << AW)));
        check("cti", 32'(wb_cti), (n - beats > 1) ? 32'b010 : 32'b111);
      end else if (started && !ended && !done) begin
        check("cyc_held", 32'(wb_cyc), 32'd1);
      end
      if (wb_cyc && wb_stb && wb_err) ended = 1;
      else if (wb_cyc && wb_stb && wb_ack) begin
        beats++;
        if (beats == n) ended = 1;
      end
      if (rd_valid) begin
        if (rd_seen == 0) first_rd_c = c;
        rd_seen++;
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        got_done = 1;
        done_c   = c;
        check("err", 32'(err), 32'(exp_err));
        check("cyc_at_done", 32'(wb_cyc), 32'd0);
        check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
      end
      c++;
    end
    wr_valid = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("beats", 32'(beats), 32'(nexp));
    check("rd_count", 32'(rd_seen), we ? 32'd0 : 32'(nexp));
    if (no_ack) check("timeout_bus_cycles", 32'(stb_cycles), 32'(TIMEOUT));
    if (!we && !no_ack && !exp_err && stall_pct == 0) begin
      check("rd_first_cycle", 32'(first_rd_c), 32'd3);
      check("rd_done_cycle", 32'(done_c), 32'(n + 2));
      check("rd_bus_cycles", 32'(stb_cycles), 32'(n + 1));
    end
    if (we && !exp_err && stall_pct == 0 && gap_at < 0) begin
      check("wr_done_cycle", 32'(done_c), 32'(n + 3));
      check("wr_no_bubbles", 32'(bubbles), 32'd0);
    end
    if (we && gap_at >= 0 && gap_at < n) check("wr_bubble_seen", 32'(bubbles > 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_dn;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; sl_err_beat = 0; sl_no_ack = 0; sl_load = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[4] = 32'hDEADBEEF;
    ref_mem[4]  = 32'hDEADBEEF;
    sl_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 sl_load = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_adr", 32'(wb_adr), 32'd0);
    check("rst_cti", 32'(wb_cti), 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(1'b0, 10'h010, 1, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b1, 10'h000, 4, 0, 1'b0, 0, -1, 1'b1);
    run_cmd(1'b0, 10'h000, 4, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b1, 10'h040, 4, 0, 1'b0, 0, 2, 1'b0);
    run_cmd(1'b0, 10'h040, 4, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b0, 10'h3F8, 4, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b0, 10'h080, 4, 2, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b0, 10'h0C0, 4, 0, 1'b1, 0, -1, 1'b0);
    run_cmd(1'b0, 10'h0D3, 0, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b1, 10'h3F0, MAXLEN, 0, 1'b0, 0, -1, 1'b0);
    run_cmd(1'b0, 10'h3F0, MAXLEN, 0, 1'b0, 0, -1, 1'b0);

    // Reset in the middle of an 8-beat read
    sl_err_beat = 0; sl_no_ack = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h100; cmd_len = LW'(8);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    n_dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || rd_valid || wb_cyc) n_dn++;
    end
    check("midrst_quiet", 32'(n_dn), 32'd0);

    for (int k = 0; k < 40; k++) begin
      bit we, na;
      int len, eb;
      repeat ($urandom_range(2)) @(negedge clk);
      we  = $urandom_range(1);
      len = $urandom_range(MAXLEN);
      eb  = ($urandom_range(7) == 0) ? $urandom_range(1, (len == 0) ? 1 : len) : 0;
      na  = ($urandom_range(19) == 0);
      run_cmd(we, AW'($urandom), len, eb, na, $urandom_range(50), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
